// File: rtl/fsm_code_if.sv
// Code-stream bus between the sequencing FSM side and fsm_code_checker.
// Optional port err_code_val exists only when FSM_CHK_CAPTURE_EN is defined.
interface fsm_code_if #(
  parameter int CNT_W = 16
);
  logic             code_vld;
  logic [3:0]       code_in;
  logic             clr_cnt;
  logic [CNT_W-1:0] long_cnt;
  logic [CNT_W-1:0] short_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_pulse;
  logic [1:0]       err_type;
  logic             in_sync;
`ifdef FSM_CHK_CAPTURE_EN
  logic [3:0]       err_code_val;
`endif

  modport master (
    output code_vld, code_in, clr_cnt,
`ifdef FSM_CHK_CAPTURE_EN
    input  err_code_val,
`endif
    input  long_cnt, short_cnt, err_cnt, err_pulse, err_type, in_sync
  );

  modport slave (
    input  code_vld, code_in, clr_cnt,
`ifdef FSM_CHK_CAPTURE_EN
    output err_code_val,
`endif
    output long_cnt, short_cnt, err_cnt, err_pulse, err_type, in_sync
  );
endinterface

// File: rtl/fsm_code_checker.sv
// Monitor for the 0/5/10 code stream: checks header-to-idle gap lengths, counts frames and errors.
// Define FSM_CHK_CAPTURE_EN to add err_code_val, which latches the offending code on each error.
module fsm_code_checker #(
  parameter int CNT_W     = 16,
  parameter int GAP_LONG  = 5,
  parameter int GAP_SHORT = 3
) (
  input logic       clk,
  input logic       rst,
  fsm_code_if.slave bus
);

  localparam int GAP_MAX = (GAP_LONG > GAP_SHORT) ? GAP_LONG : GAP_SHORT;
  localparam int GW      = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [3:0] CODE_IDLE  = 4'd0;
  localparam logic [3:0] CODE_SHORT = 4'd5;
  localparam logic [3:0] CODE_LONG  = 4'd10;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    GAP  = 2'd1,
    HEAD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_ILLEGAL   = 2'd1,
    ERR_SHORT_GAP = 2'd2,
    ERR_LONG_GAP  = 2'd3
  } err_t;

  state_t           state;
  logic [GW-1:0]    gcnt;
  logic [GW-1:0]    exp_len;
  logic             hdr_long;
  logic [CNT_W-1:0] long_cnt;
  logic [CNT_W-1:0] short_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_pulse;
  err_t             err_type;
  logic             in_sync;

  logic             is_idle;
  logic             is_hdr;
  logic             hdr_is_long;
  logic [GW-1:0]    gcnt_inc;
  logic [GW-1:0]    gap_sel;
  logic             frame_done;
  logic             err_hit;
  err_t             err_kind;

  assign is_idle     = (bus.code_in == CODE_IDLE);
  assign hdr_is_long = (bus.code_in == CODE_LONG);
  assign is_hdr      = hdr_is_long || (bus.code_in == CODE_SHORT);
  assign gcnt_inc    = gcnt + 1'b1;
  assign gap_sel     = hdr_is_long ? GW'(GAP_LONG) : GW'(GAP_SHORT);
  assign err_hit     = (err_kind != ERR_NONE);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    err_kind   = ERR_NONE;
    frame_done = 1'b0;
    if (bus.code_vld) begin
      unique case (state)
        HUNT: begin
          if (!is_idle && !is_hdr) err_kind = ERR_ILLEGAL;
        end
        GAP: begin
          if (is_idle)     frame_done = (gcnt_inc == exp_len);
          else if (is_hdr) err_kind   = ERR_SHORT_GAP;
          else             err_kind   = ERR_ILLEGAL;
        end
        HEAD: begin
          if (is_idle)      err_kind = ERR_LONG_GAP;
          else if (!is_hdr) err_kind = ERR_ILLEGAL;
        end
        default: err_kind = ERR_NONE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      gcnt      <= '0;
      exp_len   <= '0;
      hdr_long  <= 1'b0;
      long_cnt  <= '0;
      short_cnt <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
      err_type  <= ERR_NONE;
      in_sync   <= 1'b0;
    end else begin
      err_pulse <= err_hit;

      if (err_hit) begin
        err_type <= err_kind;
        in_sync  <= 1'b0;
      end else if (frame_done) begin
        in_sync  <= 1'b1;
      end

      if (bus.code_vld) begin
        unique case (state)
          HUNT: begin
            if (is_hdr) begin
              state    <= GAP;
              exp_len  <= gap_sel;
              gcnt     <= '0;
              hdr_long <= hdr_is_long;
            end
          end
          GAP: begin
            if (is_idle) begin
              if (frame_done) begin
                state <= HEAD;
                gcnt  <= '0;
              end else begin
                gcnt  <= gcnt_inc;
              end
            end else if (is_hdr) begin
              // Resync: the unexpected header starts a fresh frame.
              exp_len  <= gap_sel;
              gcnt     <= '0;
              hdr_long <= hdr_is_long;
            end else begin
              state <= HUNT;
              gcnt  <= '0;
            end
          end
          HEAD: begin
            if (is_hdr) begin
              state    <= GAP;
              exp_len  <= gap_sel;
              gcnt     <= '0;
              hdr_long <= hdr_is_long;
            end else begin
              state <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end

      // Clear beats a same-cycle increment; counters stick at all-ones.
      if (bus.clr_cnt) begin
        long_cnt  <= '0;
        short_cnt <= '0;
        err_cnt   <= '0;
      end else begin
        if (frame_done && hdr_long && (long_cnt != '1))   long_cnt  <= long_cnt + 1'b1;
        if (frame_done && !hdr_long && (short_cnt != '1)) short_cnt <= short_cnt + 1'b1;
        if (err_hit && (err_cnt != '1))                   err_cnt   <= err_cnt + 1'b1;
      end
    end
  end

`ifdef FSM_CHK_CAPTURE_EN
  logic [3:0] err_code_val;

  always_ff @(posedge clk) begin
    if (rst)          err_code_val <= '0;
    else if (err_hit) err_code_val <= bus.code_in;
  end

  assign bus.err_code_val = err_code_val;
`endif

  assign bus.long_cnt  = long_cnt;
  assign bus.short_cnt = short_cnt;
  assign bus.err_cnt   = err_cnt;
  assign bus.err_pulse = err_pulse;
  assign bus.err_type  = err_type;
  assign bus.in_sync   = in_sync;

endmodule
